// File: rtl/icap_s6_pkg.sv
// Shared types, ICAP command words and byte bit-reversal helpers for the
// Spartan-6 ICAP sequencer.
package icap_s6_pkg;

    typedef enum logic [2:0] {
        STARTUP,
        IDLE,
        WR_SEQ,
        RD_SW,
        RD_WAIT,
        WR_SW,
        DESYNC
    } state_t;

    typedef enum logic [1:0] {
        SEQ_READ,
        SEQ_BOOT,
        SEQ_DESYNC
    } seq_t;

    // Which runtime field, if any, replaces or extends the ROM word at a step.
    typedef enum logic [1:0] {
        FLD_NONE,
        FLD_REG,
        FLD_ADDR_LO,
        FLD_ADDR_HI
    } field_t;

    localparam logic [15:0] SYNC0       = 16'hFFFF;
    localparam logic [15:0] SYNC1       = 16'hAA99;
    localparam logic [15:0] SYNC2       = 16'h5566;
    localparam logic [15:0] NOOP        = 16'h2000;
    localparam logic [15:0] HDR_GEN1    = 16'h3261;
    localparam logic [15:0] HDR_GEN2    = 16'h3281;
    localparam logic [15:0] HDR_CMD     = 16'h30A1;
    localparam logic [15:0] CMD_IPROG   = 16'h000E;
    localparam logic [15:0] CMD_DESYNC  = 16'h000D;
    localparam logic [15:0] RD_HDR_BASE = 16'h2801;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    function automatic logic [15:0] swap16(input logic [15:0] w);
        return {bit_rev8(w[15:8]), bit_rev8(w[7:0])};
    endfunction

endpackage

// File: rtl/icap_s6_ctrl_if.sv
// Fabric-side request/response bus of the ICAP sequencer.
interface icap_s6_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [5:0]  req_reg;
    logic [23:0] req_boot_addr;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_reg, req_boot_addr,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_reg, req_boot_addr,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/icap_s6_seq_rom.sv
// Word-stream ROM: constant ICAP word, field-insert code and last-word flag
// for each step of the read, reboot and desync streams.
module icap_s6_seq_rom
    import icap_s6_pkg::*;
(
    input  seq_t        sel,
    input  logic [3:0]  step,
    output logic [15:0] word,
    output field_t      field,
    output logic        last
);

    always_comb begin
        word  = SYNC0;
        field = FLD_NONE;
        last  = 1'b0;
        case (sel)
            SEQ_READ: begin
                case (step)
                    4'd0: word = SYNC0;
                    4'd1: word = SYNC1;
                    4'd2: word = SYNC2;
                    4'd3: word = NOOP;
                    4'd4: begin
                        word  = RD_HDR_BASE;
                        field = FLD_REG;
                    end
                    4'd5: word = NOOP;
                    4'd6: begin
                        word = NOOP;
                        last = 1'b1;
                    end
                    default: ;
                endcase
            end
            SEQ_BOOT: begin
                case (step)
                    4'd0:  word = SYNC0;
                    4'd1:  word = SYNC1;
                    4'd2:  word = SYNC2;
                    4'd3:  word = HDR_GEN1;
                    4'd4: begin
                        word  = 16'h0000;
                        field = FLD_ADDR_LO;
                    end
                    4'd5:  word = HDR_GEN2;
                    4'd6: begin
                        word  = 16'h0000;
                        field = FLD_ADDR_HI;
                    end
                    4'd7:  word = HDR_CMD;
                    4'd8:  word = CMD_IPROG;
                    4'd9:  word = NOOP;
                    4'd10: word = NOOP;
                    4'd11: begin
                        word = NOOP;
                        last = 1'b1;
                    end
                    default: ;
                endcase
            end
            SEQ_DESYNC: begin
                case (step)
                    4'd0: word = HDR_CMD;
                    4'd1: word = CMD_DESYNC;
                    4'd2: word = NOOP;
                    4'd3: begin
                        word = NOOP;
                        last = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/icap_s6_ctrl.sv
// Spartan-6 ICAP sequencer: one register read or multiboot reboot at a time.
// All outputs are registered from the next-state decode.
module icap_s6_ctrl
    import icap_s6_pkg::*;
#(
    parameter bit         BIT_SWAP   = 1'b1,
    parameter logic [7:0] SPI_OPCODE = 8'h0B,
    parameter int         RD_TIMEOUT = 256,
    parameter int         INIT_QUIET = 4
) (
    input  logic          clk,
    input  logic          rst,
    icap_s6_ctrl_if.slave bus,
    output logic          icap_ce,
    output logic          icap_write,
    output logic [15:0]   icap_i,
    input  logic [15:0]   icap_o,
    input  logic          icap_busy
);

    localparam int CNT_MAX = (RD_TIMEOUT > INIT_QUIET) ? RD_TIMEOUT : INIT_QUIET;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] QUIET_CNT    = CNT_W'(INIT_QUIET);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RD_TIMEOUT - 1);

    state_t            state, state_nx;
    seq_t              seq, seq_nx;
    logic [3:0]        step, step_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [5:0]        rd_reg;
    logic [23:0]       addr_q;
    logic [15:0]       data_q;
    logic              err_q;
    logic              last_q;
    logic              accept, capture, timeout, rsp_fire;
    logic [15:0]       rom_word, word_nx, i_nx;
    field_t            rom_field;
    logic              rom_last;
    logic              ce_nx, write_nx;

    // ROM is addressed with the next step so its word lands in the output
    // register on the same edge the step is entered.
    icap_s6_seq_rom u_rom (
        .sel   (seq_nx),
        .step  (step_nx),
        .word  (rom_word),
        .field (rom_field),
        .last  (rom_last)
    );

    always_comb begin
        state_nx = state;
        seq_nx   = seq;
        step_nx  = step;
        cnt_nx   = cnt;
        accept   = 1'b0;
        capture  = 1'b0;
        timeout  = 1'b0;
        rsp_fire = 1'b0;
        case (state)
            STARTUP: begin
                if (cnt == QUIET_CNT) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (icap_busy) begin
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    accept   = 1'b1;
                    state_nx = WR_SEQ;
                    seq_nx   = bus.req_op ? SEQ_BOOT : SEQ_READ;
                    step_nx  = 4'd0;
                end
            end
            WR_SEQ: begin
                if (last_q) begin
                    step_nx  = 4'd0;
                    state_nx = (seq == SEQ_BOOT) ? IDLE : RD_SW;
                end else begin
                    step_nx = step + 4'd1;
                end
            end
            RD_SW: begin
                if (step == 4'd2) begin
                    state_nx = RD_WAIT;
                    step_nx  = 4'd0;
                    cnt_nx   = '0;
                end else begin
                    step_nx = step + 4'd1;
                end
            end
            RD_WAIT: begin
                if (!icap_busy) begin
                    capture  = 1'b1;
                    state_nx = WR_SW;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout  = 1'b1;
                    state_nx = WR_SW;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            WR_SW: begin
                if (step == 4'd1) begin
                    state_nx = DESYNC;
                    seq_nx   = SEQ_DESYNC;
                    step_nx  = 4'd0;
                end else begin
                    step_nx = step + 4'd1;
                end
            end
            DESYNC: begin
                if (last_q) begin
                    rsp_fire = 1'b1;
                    state_nx = IDLE;
                    step_nx  = 4'd0;
                end else begin
                    step_nx = step + 4'd1;
                end
            end
            default: state_nx = STARTUP;
        endcase
    end

    always_comb begin
        word_nx = rom_word;
        case (rom_field)
            FLD_REG:     word_nx = rom_word | {5'd0, rd_reg, 5'd0};
            FLD_ADDR_LO: word_nx = addr_q[15:0];
            FLD_ADDR_HI: word_nx = {SPI_OPCODE, addr_q[23:16]};
            default:     ;
        endcase
    end

    // Switching cycles walk CE/WRITE so WRITE never changes while CE is low.
    always_comb begin
        ce_nx    = 1'b1;
        write_nx = 1'b0;
        i_nx     = SYNC0;
        case (state_nx)
            WR_SEQ, DESYNC: begin
                ce_nx = 1'b0;
                i_nx  = word_nx;
            end
            RD_SW: begin
                ce_nx    = (step_nx != 4'd2);
                write_nx = (step_nx != 4'd0);
            end
            RD_WAIT: begin
                ce_nx    = 1'b0;
                write_nx = 1'b1;
            end
            WR_SW: write_nx = (step_nx == 4'd0);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= STARTUP;
            seq           <= SEQ_READ;
            step          <= 4'd0;
            cnt           <= '0;
            last_q        <= 1'b0;
            rd_reg        <= 6'd0;
            addr_q        <= 24'd0;
            data_q        <= 16'd0;
            err_q         <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 16'd0;
            bus.rsp_err   <= 1'b0;
            icap_ce       <= 1'b1;
            icap_write    <= 1'b0;
            icap_i        <= SYNC0;
        end else begin
            state  <= state_nx;
            seq    <= seq_nx;
            step   <= step_nx;
            cnt    <= cnt_nx;
            last_q <= rom_last;
            if (accept) begin
                rd_reg <= bus.req_reg;
                addr_q <= bus.req_boot_addr;
            end
            if (capture) begin
                data_q <= BIT_SWAP ? swap16(icap_o) : icap_o;
                err_q  <= 1'b0;
            end else if (timeout) begin
                data_q <= 16'd0;
                err_q  <= 1'b1;
            end
            // Ready is held off for the response cycle itself.
            bus.req_ready <= (state_nx == IDLE) && !rsp_fire;
            bus.rsp_valid <= rsp_fire;
            if (rsp_fire) begin
                bus.rsp_data <= data_q;
                bus.rsp_err  <= err_q;
            end
            icap_ce    <= ce_nx;
            icap_write <= write_nx;
            icap_i     <= BIT_SWAP ? swap16(i_nx) : i_nx;
        end
    end

endmodule
